reg_write_scheduler: RTL and testbench

- Buffers register writes from two requesters and commits them to the synth's shared register-write bus.
  - Requester 1: the SPI slave, which cannot be stalled.
  - Requester 2: an on-chip patch/note sequencer, using valid/ready.
- Commits happen only in a short burst starting at a chosen voice-operator slot of the 256-slot frame, so a parameter change does not land part-way through a voice.
- Sits between the spi/sequencer blocks and the per-stage config write ports (phase accumulator, modulator, envelope attenuator).

---
 rtl/reg_write_scheduler.sv | 176 +++++++++++++++++
 tb/tb_reg_write_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scheduler.sv
// Register-write scheduler: queues SPI and sequencer writes and commits them in a burst aligned to SYNC_SLOT.
// Optional macro REG_SCHED_GLOBAL_BYPASS_EN: global registers (number bit 14 == 0) at the head skip the slot wait.
module reg_write_scheduler #(
    parameter int         DEPTH     = 8,
    parameter int         BURST_MAX = 16,
    parameter logic [7:0] SYNC_SLOT = 8'd0
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset_n,
    input  logic [7:0]                 i_VoiceOperator,
    input  logic                       i_SPI_WriteEnable,
    input  logic [14:0]                i_SPI_WriteNumber,
    input  logic [15:0]                i_SPI_WriteValue,
    input  logic                       i_Seq_Valid,
    output logic                       o_Seq_Ready,
    input  logic [14:0]                i_Seq_WriteNumber,
    input  logic [15:0]                i_Seq_WriteValue,
    output logic                       o_RegisterWriteEnable,
    output logic [14:0]                o_RegisterWriteNumber,
    output logic [15:0]                o_RegisterWriteValue,
    output logic [$clog2(DEPTH):0]     o_Level,
    output logic                       o_Overflow,
    output logic                       o_Busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SYNC = 2'd1,
        S_DRAIN     = 2'd2
    } state_t;

    logic [30:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    state_t        r_state;
    logic [BW-1:0] r_burst;
    logic          r_busy;
    logic          r_we;
    logic [14:0]   r_num;
    logic [15:0]   r_val;

    logic          w_not_full;
    logic          w_not_empty;
    logic          w_pop;
    logic          w_push_spi;
    logic          w_push_seq;
    logic          w_push;
    logic [30:0]   w_push_data;
    logic [30:0]   w_head;
    logic [LW-1:0] w_level_next;
    state_t        w_state_next;
    logic [BW-1:0] w_burst_next;

    assign w_not_full  = (r_level < LW'(DEPTH));
    assign w_not_empty = (r_level != '0);
    assign w_head      = r_mem[r_rd_ptr];

`ifdef REG_SCHED_GLOBAL_BYPASS_EN
    logic w_head_global;
    logic w_empty_after_pop;
    assign w_head_global     = ~w_head[30];
    // Only reachable with a single entry and no push this cycle (not full, so any request would be accepted).
    assign w_empty_after_pop = (r_level == LW'(1)) && !i_SPI_WriteEnable && !i_Seq_Valid;
`endif

    always_comb begin
        w_pop        = 1'b0;
        w_state_next = r_state;
        w_burst_next = r_burst;
        case (r_state)
            S_IDLE: begin
`ifdef REG_SCHED_GLOBAL_BYPASS_EN
                if (w_not_empty && w_head_global) begin
                    w_pop = 1'b1;
                end else if (w_not_empty) begin
                    w_state_next = S_WAIT_SYNC;
                end
`else
                if (w_not_empty) begin
                    w_state_next = S_WAIT_SYNC;
                end
`endif
            end
            S_WAIT_SYNC: begin
                if (i_VoiceOperator == SYNC_SLOT) begin
                    w_state_next = S_DRAIN;
                    w_pop        = w_not_empty;
                    w_burst_next = w_not_empty ? BW'(1) : '0;
                end
`ifdef REG_SCHED_GLOBAL_BYPASS_EN
                else if (w_not_empty && w_head_global) begin
                    w_pop = 1'b1;
                    if (w_empty_after_pop) begin
                        w_state_next = S_IDLE;
                    end
                end
`endif
            end
            S_DRAIN: begin
                if (!w_not_empty || (r_burst == BW'(BURST_MAX))) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_pop        = 1'b1;
                    w_burst_next = r_burst + BW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // SPI wins the single push port; the sequencer only sees ready when SPI is quiet.
    assign o_Seq_Ready  = !i_SPI_WriteEnable && (w_not_full || w_pop);
    assign w_push_spi   = i_SPI_WriteEnable && (w_not_full || w_pop);
    assign w_push_seq   = i_Seq_Valid && o_Seq_Ready;
    assign w_push       = w_push_spi || w_push_seq;
    assign w_push_data  = i_SPI_WriteEnable ? {i_SPI_WriteNumber, i_SPI_WriteValue}
                                            : {i_Seq_WriteNumber, i_Seq_WriteValue};
    assign w_level_next = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_we       <= 1'b0;
            r_num      <= '0;
            r_val      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_num    <= w_head[30:16];
                r_val    <= w_head[15:0];
            end
            r_we    <= w_pop;
            r_level <= w_level_next;
            if (i_SPI_WriteEnable && !w_push_spi) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= S_IDLE;
            r_burst <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_burst <= w_burst_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    assign o_RegisterWriteEnable = r_we;
    assign o_RegisterWriteNumber = r_num;
    assign o_RegisterWriteValue  = r_val;
    assign o_Level               = r_level;
    assign o_Overflow            = r_overflow;
    assign o_Busy                = r_busy;

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench for reg_write_scheduler (DEPTH=8, BURST_MAX=4, SYNC_SLOT=0); commits are logged with their slot.
module tb_reg_write_scheduler;
    localparam int DEPTH     = 8;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vo;
    logic        spi_we;
    logic [14:0] spi_num;
    logic [15:0] spi_val;
    logic        seq_valid;
    logic        seq_ready;
    logic [14:0] seq_num;
    logic [15:0] seq_val;
    logic        o_we;
    logic [14:0] o_num;
    logic [15:0] o_val;
    logic [3:0]  o_level;
    logic        o_ovf;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;

    logic [14:0] q_num [$];
    logic [15:0] q_val [$];
    logic [7:0]  q_vo  [$];

    always #5 clk = ~clk;

    reg_write_scheduler #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX), .SYNC_SLOT(8'd0)) dut (
        .i_Clock               (clk),
        .i_Reset_n             (rst_n),
        .i_VoiceOperator       (vo),
        .i_SPI_WriteEnable     (spi_we),
        .i_SPI_WriteNumber     (spi_num),
        .i_SPI_WriteValue      (spi_val),
        .i_Seq_Valid           (seq_valid),
        .o_Seq_Ready           (seq_ready),
        .i_Seq_WriteNumber     (seq_num),
        .i_Seq_WriteValue      (seq_val),
        .o_RegisterWriteEnable (o_we),
        .o_RegisterWriteNumber (o_num),
        .o_RegisterWriteValue  (o_val),
        .o_Level               (o_level),
        .o_Overflow            (o_ovf),
        .o_Busy                (o_busy)
    );

    always @(negedge clk) begin
        if (rst_n && o_we) begin
            q_num.push_back(o_num);
            q_val.push_back(o_val);
            q_vo.push_back(vo);
            $display("commit num=%h val=%h slot=%0d", o_num, o_val, vo);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        vo = vo + 8'd1;
    endtask

    task automatic run_to(input logic [7:0] v);
        for (int i = 0; i < 300 && vo != v; i++) tick();
    endtask

    task automatic clear_log();
        q_num.delete();
        q_val.delete();
        q_vo.delete();
    endtask

    function automatic logic [31:0] log_num(input int i);
        return (i < q_num.size()) ? 32'(q_num[i]) : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] log_val(input int i);
        return (i < q_val.size()) ? 32'(q_val[i]) : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] log_vo(input int i);
        return (i < q_vo.size()) ? 32'(q_vo[i]) : 32'hxxxx_xxxx;
    endfunction

    task automatic spi_write(input logic [14:0] n, input logic [15:0] v);
        spi_we  = 1'b1;
        spi_num = n;
        spi_val = v;
        tick();
        spi_we  = 1'b0;
    endtask

    task automatic seq_push(input logic [14:0] n, input logic [15:0] v);
        bit done;
        done      = 1'b0;
        seq_valid = 1'b1;
        seq_num   = n;
        seq_val   = v;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            done = seq_ready;
            tick();
        end
        seq_valid = 1'b0;
        check("seq_push_accepted", 32'(done), 32'd1);
    endtask

    // Expects `count` contiguous commits numbered base+k, starting one slot after slot 0.
    task automatic check_frame(input string tag, input logic [14:0] base, input int count);
        check({tag, "_count"}, 32'(q_num.size()), 32'(count));
        for (int k = 0; k < count; k++) begin
            check({tag, "_num"}, log_num(k), 32'(base + 15'(k)));
            check({tag, "_slot"}, log_vo(k), 32'(k + 1));
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        vo        = 8'd100;
        spi_we    = 1'b0;
        spi_num   = '0;
        spi_val   = '0;
        seq_valid = 1'b0;
        seq_num   = '0;
        seq_val   = '0;
        #1 rst_n  = 1'b0;
        #1;
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_num", 32'(o_num), 32'd0);
        check("rst_val", 32'(o_val), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single SPI write waits for slot 0
        clear_log();
        spi_write(15'h4012, 16'hBEEF);
        check("t1_level", 32'(o_level), 32'd1);
        tick();
        check("t1_busy", 32'(o_busy), 32'd1);
        run_to(8'd0);
        check("t1_no_early", 32'(q_num.size()), 32'd0);
        run_to(8'd5);
        check("t1_count", 32'(q_num.size()), 32'd1);
        check("t1_num", log_num(0), 32'h4012);
        check("t1_val", log_val(0), 32'hBEEF);
        check("t1_slot", log_vo(0), 32'd1);
        check("t1_busy_after", 32'(o_busy), 32'd0);
        check("t1_level_after", 32'(o_level), 32'd0);
        check("t1_hold_num", 32'(o_num), 32'h4012);

        // SPI and sequencer collide
        clear_log();
        spi_we = 1'b1; spi_num = 15'h4100; spi_val = 16'h0001;
        seq_valid = 1'b1; seq_num = 15'h4101; seq_val = 16'h0002;
        #1;
        check("t2_ready_blocked", 32'(seq_ready), 32'd0);
        tick();
        spi_we = 1'b0;
        #1;
        check("t2_ready_next", 32'(seq_ready), 32'd1);
        tick();
        seq_valid = 1'b0;
        run_to(8'd0);
        run_to(8'd5);
        check("t2_count", 32'(q_num.size()), 32'd2);
        check("t2_num0", log_num(0), 32'h4100);
        check("t2_val0", log_val(0), 32'h0001);
        check("t2_slot0", log_vo(0), 32'd1);
        check("t2_num1", log_num(1), 32'h4101);
        check("t2_val1", log_val(1), 32'h0002);
        check("t2_slot1", log_vo(1), 32'd2);

        // Fill to DEPTH, then overflow
        clear_log();
        for (int i = 0; i < DEPTH; i++) spi_write(15'h4200 + 15'(i), 16'(i));
        check("t3_full_level", 32'(o_level), 32'd8);
        check("t3_ovf_before", 32'(o_ovf), 32'd0);
        seq_valid = 1'b1; seq_num = 15'h4333; seq_val = 16'h0;
        #1;
        check("t3_ready_full", 32'(seq_ready), 32'd0);
        seq_valid = 1'b0;
        spi_write(15'h42FF, 16'hDEAD);
        check("t3_ovf_set", 32'(o_ovf), 32'd1);
        check("t3_level_sat", 32'(o_level), 32'd8);
        run_to(8'd0);
        run_to(8'd10);
        check_frame("t3_f1", 15'h4200, 4);
        check("t3_level_mid", 32'(o_level), 32'd4);
        clear_log();
        run_to(8'd0);
        run_to(8'd10);
        check_frame("t3_f2", 15'h4204, 4);
        check("t3_level_end", 32'(o_level), 32'd0);
        check("t3_ovf_sticky", 32'(o_ovf), 32'd1);

        // 20 sequencer entries, four per frame, then a short frame
        for (int k = 0; k < 8; k++) seq_push(15'h4300 + 15'(k), 16'(k));
        for (int f = 0; f < 5; f++) begin
            clear_log();
            run_to(8'd0);
            run_to(8'd10);
            check_frame("t4_frame", 15'h4300 + 15'(4 * f), 4);
            if (f < 3)
                for (int k = 0; k < 4; k++) seq_push(15'h4308 + 15'(4 * f + k), 16'(8 + 4 * f + k));
        end
        check("t4_level_empty", 32'(o_level), 32'd0);
        seq_push(15'h4320, 16'h0020);
        seq_push(15'h4321, 16'h0021);
        clear_log();
        run_to(8'd0);
        run_to(8'd10);
        check_frame("t4_short", 15'h4320, 2);
        check("t4_short_busy", 32'(o_busy), 32'd0);

        // Reset during the second strobe
        for (int k = 0; k < 5; k++) seq_push(15'h4400 + 15'(k), 16'(k));
        run_to(8'd0);
        tick();
        tick();
        check("t5_strobe2_we", 32'(o_we), 32'd1);
        check("t5_strobe2_num", 32'(o_num), 32'h4401);
        rst_n = 1'b0;
        #1;
        check("t5_rst_we", 32'(o_we), 32'd0);
        check("t5_rst_num", 32'(o_num), 32'd0);
        check("t5_rst_val", 32'(o_val), 32'd0);
        check("t5_rst_level", 32'(o_level), 32'd0);
        check("t5_rst_busy", 32'(o_busy), 32'd0);
        check("t5_rst_ovf", 32'(o_ovf), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_log();
        run_to(8'd0);
        run_to(8'd10);
        check("t5_no_strobe", 32'(q_num.size()), 32'd0);
        check("t5_level_after", 32'(o_level), 32'd0);

        // Global register followed by a voice register
        run_to(8'd50);
        clear_log();
        spi_write(15'h0100, 16'h0003);
        spi_write(15'h4000, 16'h0004);
        run_to(8'd0);
        run_to(8'd10);
        check("t6_count", 32'(q_num.size()), 32'd2);
        check("t6_num0", log_num(0), 32'h0100);
        check("t6_val0", log_val(0), 32'h0003);
        check("t6_num1", log_num(1), 32'h4000);
        check("t6_val1", log_val(1), 32'h0004);
        check("t6_slot1", log_vo(1), 32'd1 + (`ifdef REG_SCHED_GLOBAL_BYPASS_EN 32'd0 `else 32'd1 `endif));
`ifdef REG_SCHED_GLOBAL_BYPASS_EN
        check("t6_slot0", log_vo(0), 32'd52);
`else
        check("t6_slot0", log_vo(0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
